// File: rtl/midprocess_zf_nx_if.sv
// Row bus for the back-substitution engine: capture handshake, row operands and result.
// The master drives the row and its strobe; the slave reports readiness and the saturated numerator.
interface midprocess_zf_nx_if #(
    parameter int W    = 16,
    parameter int NMAX = 4
);
    localparam int NTW = $clog2(NMAX + 1);

    logic              accept_in;
    logic              ready_out;
    logic              accept_out;
    logic [NTW-1:0]    n_terms;
    logic [W-1:0]      z_in;
    logic [NMAX*W-1:0] R_row;
    logic [NMAX*W-1:0] X_pre;
    logic [W-1:0]      X_mid;

    modport master (
        output accept_in, n_terms, z_in, R_row, X_pre,
        input  ready_out, accept_out, X_mid
    );

    modport slave (
        input  accept_in, n_terms, z_in, R_row, X_pre,
        output ready_out, accept_out, X_mid
    );
endinterface

// File: rtl/midprocess_zf_nx.sv
// Back-substitution numerator x_num = z - sum(r_j*x_j) via one serial MAC, then round-down and saturate.
// Latency: result pulse n_terms+1 enabled edges after capture; one row per n_terms+2 cycles.
// Backpressure: ready_out high only in IDLE; strobes while busy are dropped; enable low freezes everything.
module midprocess_zf_nx #(
    parameter int W    = 16,
    parameter int FRAC = 12,
    parameter int NMAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    midprocess_zf_nx_if.slave  io
);
    localparam int NTW = $clog2(NMAX + 1);
    // Headroom for NMAX full-width products on top of the shifted z: never overflows.
    localparam int AW  = 2*W + $clog2(NMAX) + 1;

    localparam logic signed [AW-1:0] SAT_HI = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_LO = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                 state, state_nxt;
    logic [NTW-1:0]         n_clamp, nt_r, cnt;
    logic [NMAX*W-1:0]      r_r, x_r;
    logic signed [AW-1:0]   acc, acc_shr, z_ext;
    logic signed [W-1:0]    r_j, x_j;
    logic signed [2*W-1:0]  prod;
    logic [W-1:0]           sat_val;
    logic                   capture, mac_step, finish;

    assign n_clamp = (io.n_terms > NTW'(NMAX)) ? NTW'(NMAX) : io.n_terms;
    assign z_ext   = AW'($signed(io.z_in));
    assign r_j     = r_r[cnt*W +: W];
    assign x_j     = x_r[cnt*W +: W];
    assign prod    = r_j * x_j;
    assign acc_shr = acc >>> FRAC;

    always_comb begin
        sat_val = acc_shr[W-1:0];
        if (acc_shr > SAT_HI)
            sat_val = {1'b0, {(W-1){1'b1}}};
        else if (acc_shr < SAT_LO)
            sat_val = {1'b1, {(W-1){1'b0}}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else if (enable)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (io.accept_in) state_nxt = (n_clamp == '0) ? DONE : MAC;
            MAC:     if (cnt == nt_r - NTW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        io.ready_out = (state == IDLE);
        capture      = (state == IDLE) && io.accept_in;
        mac_step     = (state == MAC);
        finish       = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt           <= '0;
            nt_r          <= '0;
            acc           <= '0;
            r_r           <= '0;
            x_r           <= '0;
            io.X_mid      <= '0;
            io.accept_out <= 1'b0;
        end else if (enable) begin
            io.accept_out <= finish;
            if (capture) begin
                r_r  <= io.R_row;
                x_r  <= io.X_pre;
                nt_r <= n_clamp;
                acc  <= z_ext <<< FRAC;
                cnt  <= '0;
            end
            if (mac_step) begin
                acc <= acc - AW'(prod);
                cnt <= cnt + NTW'(1);
            end
            if (finish)
                io.X_mid <= sat_val;
        end
    end
endmodule

// File: doc/midprocess_zf_nx.md
# midprocess_zf_nx

Parametrised back-substitution row engine for the ZF detector. It computes one numerator of the upper-triangular solve: x_num = z − Σ r_j·x_j. It does this with a single serial multiply-accumulate over up to NMAX already-solved symbols, then rounds and saturates the result to the fixed-point sample format. It generalises the 2×2 mid-process stage to N×N channels: at runtime the term count per row is selectable, so one instance serves every row of a back-substitution pass. It sits between the Q^H·y stage and the per-row divide-by-r_ii stage.

## Interface
- W, 16, sample width (signed two's complement)
- FRAC, 12, fractional bits of every sample (Q(W−FRAC).FRAC)
- NMAX, 4, maximum number of off-diagonal terms per row (≥1)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset; the only reset in the block
- enable  in  1  global clock enable; low = every register holds
- accept_in  in  1  input-valid strobe; sampled only when ready_out=1 and enable=1
- ready_out  out  1  block idle and able to capture a row
- accept_out  out  1  one-cycle result-valid pulse
- n_terms  in  $clog2(NMAX+1)  number of valid terms this row; values >NMAX clamp to NMAX
- z_in  in  W  Q^H·y element of this row
- R_row  in  NMAX·W  off-diagonal R elements; term j at [j·W +: W]
- X_pre  in  NMAX·W  previously solved X elements; term j at [j·W +: W]
- X_mid  out  W  saturated numerator; held until the next result

## Operation
- FSM states: IDLE, MAC, DONE. ready_out = (state==IDLE), combinational.
- IDLE, on enable & accept_in:
  - capture R_row, X_pre and the clamped n_terms into internal registers.
  - acc ← sign-extended z_in << FRAC; cnt ← 0.
  - go to MAC if n_terms≠0, else go to DONE.
- MAC, each enabled cycle:
  - acc ← acc − R[cnt]·X[cnt] (full 2W-bit signed product).
  - cnt ← cnt+1.
  - go to DONE when cnt==n_terms−1.
- DONE, on enable:
  - X_mid ← sat(acc >>> FRAC), using arithmetic shift (floor).
  - sat clamps to [−2^(W−1), 2^(W−1)−1].
  - accept_out ← 1; return to IDLE.
- accept_out is cleared on every other enabled edge.
- Accumulator width is 2W + $clog2(NMAX) + 1, which guarantees no intermediate overflow; saturation is applied only at the output.
- Inputs are not re-sampled outside IDLE. Changing them mid-operation has no effect.
- accept_in while ready_out=0 is ignored and not queued.

## Timing
- Reset values: state IDLE, cnt 0, acc 0, X_mid 0, accept_out 0. ready_out reads 1 during reset, but accept_in is ignored while reset is high.
- Latency: counting from the capture edge, accept_out rises n_terms+1 enabled edges later. Example: n_terms=2 → high after the 3rd edge.
- Throughput: one row per n_terms+2 cycles. A new row may be captured in the same cycle that accept_out is high, since state is already IDLE.
- enable low: FSM, cnt, acc, X_mid and accept_out all hold. A pulsed accept_out therefore stretches while enable is low.
- Reset asserted mid-MAC or in DONE: all state is cleared immediately. No accept_out is produced for the aborted row.
- Simultaneous reset and accept_in: reset wins and the row is dropped.

## Test plan
- **Reference row.** W=16, FRAC=12, n_terms=2, z_in=0x3333, R_row={0x0666,0x0999}, X_pre={0x0E66,0x0666} (term 0 in the low half). Required: X_mid=0x299A, accept_out high for exactly 1 cycle after the 3rd edge following capture.
- **Zero terms.** n_terms=0, z_in=0xC000. Required: X_mid=0xC000 after 1 edge. Also n_terms=7 with NMAX=4 must behave as n_terms=4.
- **Saturation.**
  - Positive: z_in=0x7FFF, R[0]=0x8000, X[0]=0x7FFF, n_terms=1 → X_mid=0x7FFF.
  - Negative: z_in=0x8000, R[0]=0x7FFF, X[0]=0x7FFF → X_mid=0x8000.
- **Back-to-back rows.** Hold accept_in high continuously with rows n_terms=1 then n_terms=3. Required: captures are 3 then 5 cycles apart, each result is correct, and no row is lost or duplicated.
- **Stall.** Drop enable for 4 cycles in the middle of MAC. Required: same X_mid as the unstalled run, with latency extended by exactly 4 cycles.
- **Mid-operation reset.** Assert reset during MAC. Required: on the next edge X_mid=0, accept_out=0 and state is IDLE. The next row processes correctly.
